// File: rtl/priority_req_ctrl_8_v.sv
// Request-capture stage feeding the 8-to-3 priority encoder: sticky pending, mask, lowest-index grant over valid/ack.
// Optional macro PRC_EDGE_DET_EN: request events on rising edges of i_req instead of levels.
module priority_req_ctrl_8_v #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic [7:0] i_mask,
    input  logic       i_ack,
    input  logic       i_ovr_clr,
    output logic       o_valid,
    output logic [2:0] o_code,
    output logic [7:0] o_pending,
    output logic [7:0] o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_HOLDOFF
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [2:0] code_next;
    logic       ack_fire;
    logic [7:0] req_evt;
    logic [7:0] clr_vec;
    logic [7:0] ovr_evt;
    logic [7:0] cand;
    logic [2:0] sel;
    logic       any;

`ifdef PRC_EDGE_DET_EN
    logic [7:0] req_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_prev <= '0;
        end else begin
            req_prev <= i_req;
        end
    end

    assign req_evt = i_req & ~req_prev;
`else
    assign req_evt = i_req;
`endif

    // Lowest index wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        cand = o_pending & ~i_mask;
        any  = |cand;
        sel  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                sel = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = o_code;
        ack_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    code_next  = sel;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_ack) begin
                    ack_fire = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next   = 8'(HOLDOFF - 1);
                        state_next = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A same-cycle request on the served line masks the clear, so it is neither cleared nor an overrun.
    assign clr_vec = ack_fire ? (8'b1 << o_code) : 8'b0;
    assign ovr_evt = req_evt & o_pending & ~clr_vec;
    assign o_valid = (state == ST_PRESENT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            o_code    <= '0;
            o_pending <= '0;
            o_overrun <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            o_code    <= code_next;
            o_pending <= (o_pending & ~clr_vec) | req_evt;
            o_overrun <= (i_ovr_clr ? 8'b0 : o_overrun) | ovr_evt;
        end
    end

endmodule

// File: tb/tb_priority_req_ctrl_8_v.sv
// Scoreboard bench for priority_req_ctrl_8_v: a cycle model predicts grants and flags.
// The monitor compares the predictions against the DUT on every falling edge.
module tb_priority_req_ctrl_8_v;

    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       ovrClr;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
    logic [7:0] overrun;

    int checksTotal  = 0;
    int checksPassed = 0;
    int expQ[$];

    logic [7:0] mPend = '0;
    logic [7:0] mOvr  = '0;
    logic [7:0] mPrev = '0;
    bit         mPresenting = 1'b0;
    int         mCode = 0;
    int         mQuiet = 0;
    bit         prevValid = 1'b0;

    always #5 clk = ~clk;

    priority_req_ctrl_8_v #(.HOLDOFF(HOLD)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_mask    (mask),
        .i_ack     (ack),
        .i_ovr_clr (ovrClr),
        .o_valid   (valid),
        .o_code    (code),
        .o_pending (pending),
        .o_overrun (overrun)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour for one rising edge, applied to the inputs present at that edge.
    function automatic void modelStep();
        logic [7:0] evt;
        logic [7:0] oldPend;
        int served;
        int winner;
        oldPend = mPend;
        served  = (mPresenting && ack) ? mCode : -1;
        winner  = -1;
        for (int i = 0; i < 8; i++) begin
`ifdef PRC_EDGE_DET_EN
            evt[i] = req[i] && !mPrev[i];
`else
            evt[i] = req[i];
`endif
            mPrev[i] = req[i];
            if (ovrClr) mOvr[i] = 1'b0;
            if (evt[i] && oldPend[i] && i != served) mOvr[i] = 1'b1;
            mPend[i] = evt[i] || (oldPend[i] && i != served);
        end
        for (int i = 0; i < 8; i++) begin
            if (oldPend[i] && !mask[i]) begin
                winner = i;
                break;
            end
        end
        if (mPresenting) begin
            if (ack) begin
                mPresenting = 1'b0;
                mQuiet      = HOLD;
            end
        end else if (mQuiet > 0) begin
            mQuiet--;
        end else if (winner >= 0) begin
            mPresenting = 1'b1;
            mCode       = winner;
            expQ.push_back(winner);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPend       = '0;
            mOvr        = '0;
            mPrev       = '0;
            mPresenting = 1'b0;
            mCode       = 0;
            mQuiet      = 0;
            expQ.delete();
        end else begin
            modelStep();
        end
    end

    // Monitor: flags every cycle, and each new grant is popped from the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            checkOutput("valid", int'(valid), int'(mPresenting));
            checkOutput("pending", int'(pending), int'(mPend));
            checkOutput("overrun", int'(overrun), int'(mOvr));
            if (mPresenting) checkOutput("code_hold", int'(code), mCode);
            if (valid && !prevValid) begin
                if (expQ.size() == 0) checkOutput("grant_unexpected", 1, 0);
                else checkOutput("grant_code", int'(code), expQ.pop_front());
            end
            prevValid = valid;
        end
    end

    // ackMode: 0 = no ack, 1 = ack whenever valid is up, 2 = random ack.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m, input int ackMode, input logic c);
        @(negedge clk);
        #1;
        req    = r;
        mask   = m;
        ovrClr = c;
        case (ackMode)
            1:       ack = valid;
            2:       ack = 1'($urandom_range(0, 1));
            default: ack = 1'b0;
        endcase
    endtask

    task automatic serve(input int n, input logic [7:0] m);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, m, 1, 1'b0);
    endtask

    task automatic waitValid(input logic [7:0] m);
        for (int i = 0; i < 40; i++) begin
            if (valid) return;
            applyStimulus(8'h00, m, 0, 1'b0);
        end
        checkOutput("wait_valid_timeout", 0, 1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_code", int'(code), 0);
        checkOutput("rst_pending", int'(pending), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
    endtask

    initial begin
        logic [7:0] rndMask;
        rst_n  = 1'b0;
        req    = '0;
        mask   = '0;
        ack    = 1'b0;
        ovrClr = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] priority order");
        applyStimulus(8'hA4, 8'h00, 0, 1'b0);
        serve(25, 8'h00);

        $display("[TB] stability of presented code");
        applyStimulus(8'h20, 8'h00, 0, 1'b0);
        waitValid(8'h00);
        applyStimulus(8'h01, 8'h00, 0, 1'b0);
        applyStimulus(8'h00, 8'h00, 0, 1'b0);
        applyStimulus(8'h00, 8'h00, 0, 1'b0);
        serve(20, 8'h00);

        $display("[TB] mask then unmask");
        applyStimulus(8'h81, 8'h01, 0, 1'b0);
        serve(10, 8'h01);
        serve(10, 8'h00);

        $display("[TB] overrun and set-wins");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h08, 8'h08, 0, 1'b0);
            applyStimulus(8'h00, 8'h08, 0, 1'b0);
        end
        applyStimulus(8'h00, 8'h08, 0, 1'b1);
        applyStimulus(8'h08, 8'h08, 0, 1'b0);
        waitValid(8'h00);
        applyStimulus(8'h08, 8'h00, 1, 1'b0);
        serve(15, 8'h00);

        $display("[TB] holdoff gap");
        applyStimulus(8'h06, 8'h00, 0, 1'b0);
        serve(20, 8'h00);

        $display("[TB] held request line");
        for (int i = 0; i < 10; i++) applyStimulus(8'h02, 8'h00, 1, 1'b0);
        applyStimulus(8'h00, 8'h00, 1, 1'b1);
        serve(15, 8'h00);

        $display("[TB] random traffic");
        rndMask = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) rndMask = 8'($urandom & $urandom);
            applyStimulus(8'($urandom & $urandom & $urandom), rndMask, 2,
                          1'($urandom_range(0, 31) == 0));
        end
        serve(40, 8'h00);

        $display("[TB] reset mid-handshake");
        applyStimulus(8'h30, 8'h00, 0, 1'b0);
        waitValid(8'h00);
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        serve(5, 8'h00);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/priority_req_ctrl_8_v.md
Name: priority_req_ctrl_8_v

Overview:
Upstream request-capture stage for the 8-to-3 priority encoder. Latches 8 request lines into a sticky pending register and applies a mask. Selects the winning line with lowest-index-highest-priority, the same rule as the encoder. Presents the winning code to the consumer over a valid/ack handshake and clears the served line on acceptance.

Parameters:
HOLDOFF, 2, idle cycles forced after each ack before the next selection; legal range 0..255.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_req  input  8  request lines; bit n = request source n
i_mask  input  8  1 = line n excluded from selection; its pending bit is still kept
i_ack  input  1  consumer accepts presented code; sampled only while o_valid=1
i_ovr_clr  input  1  synchronous clear of all o_overrun bits
o_valid  output  1  o_code holds a valid winning line
o_code  output  3  index of the presented line
o_pending  output  8  current pending register
o_overrun  output  8  sticky: request event on line n while pending[n] already set

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: pending=0, o_overrun=0, o_valid=0, o_code=3'b000, holdoff counter=0, state=IDLE.
- Reset mid-handshake: drops o_valid immediately and discards all pending requests.
- Request event: req_evt[n] = i_req[n] sampled high on a clock edge (level mode; see Optional Feature).
- Pending set: req_evt[n] sets pending[n].
- Pending clear: ack of line n in PRESENT clears pending[n], unless req_evt[n] occurs in the same cycle. Set wins; pending stays 1 and no overrun is flagged.
- Overrun: req_evt[n] with pending[n]=1 and no same-cycle clear of n sets o_overrun[n].
- o_overrun clear: i_ovr_clr zeroes all bits. A new overrun event in the same cycle wins for its bit.
- Selection (combinational): sel = lowest n with pending[n] & ~i_mask[n]. any = OR of (pending & ~i_mask).
- FSM, IDLE: o_valid=0. If any=1, latch o_code<=sel and go to PRESENT.
- FSM, PRESENT: o_valid=1.
  - o_code held stable until ack. Later higher-priority requests or mask changes never retract or alter it.
  - On i_ack: clear pending[o_code], o_valid<=0.
  - HOLDOFF=0: go to IDLE.
  - HOLDOFF>0: load counter with HOLDOFF-1 and go to HOLDOFF.
- FSM, HOLDOFF: o_valid=0. Counter decrements each cycle; at 0 go to IDLE. Requests still accumulate into pending.
- Latency: i_req high at edge k sets pending at edge k. With the FSM in IDLE, o_valid rises at edge k+1.
- Minimum o_valid-low gap between successive grants: HOLDOFF+1 cycles.
- i_ack while o_valid=0 is ignored.
- All lines masked: FSM stays in IDLE, pending retained. Unmasking later triggers selection normally.
- Counter width: 8 bits; no wrap, since the counter decrements only while nonzero.

Optional Feature:
Macro: PRC_EDGE_DET_EN
- Defined: req_evt[n] = rising edge of i_req[n], using a registered previous copy reset to 0. A line held high produces exactly one event, so a held line never causes an overrun.
- Undefined: level mode. Every cycle i_req[n]=1 is an event, so a held line re-sets pending immediately after ack and flags overrun while pending.
- Latency is identical in both modes.

Test Plan:
- Reset: drive i_rst_n=0 mid-PRESENT -> o_valid=0, o_code=0, o_pending=0, o_overrun=0 asynchronously, before the next clock edge.
- Priority: pulse i_req=8'b1010_0100 for one cycle, mask=0, HOLDOFF=0, ack each grant 1 cycle after o_valid -> o_code sequence 2, 5, 7; o_pending ends 0.
- Stability: while o_code=5 is presented, pulse i_req[0] -> o_code stays 5 until ack; next grant is 0.
- Mask: pending=8'h81, i_mask=8'h01 -> o_code=7. Then unmask -> line 0 is granted next.
- Overrun/set-wins: pulse i_req[3] twice while line 3 is pending -> o_overrun=8'h08. Pulse i_req[3] in the ack cycle of line 3 -> pending[3] stays 1, no new overrun.
- Holdoff: HOLDOFF=3, two lines pending -> exactly 4 cycles of o_valid=0 between the ack cycle and the next o_valid.
- Level vs edge: hold i_req[1]=1 for 10 cycles with ack on each grant. PRC_EDGE_DET_EN undefined -> repeated grants of 1. PRC_EDGE_DET_EN defined -> a single grant, o_overrun=0.
